bootdata_ioctl_bridge: RTL and testbench

Parametrised bridge between the ZPUFlex control module's 32-bit boot-data handshake and the MiSTer-style `ioctl_*` download port seen by the core. It unpacks each host word into 8- or 16-bit writes and honours `ioctl_wait`. It enforces a byte-exact file size, tags the download with the selected file type, and reports address overflow. It sits inside the zxdos `hps_io` substitute, between `CtrlModule` and the core.

---
 rtl/bootdata_ioctl_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_bootdata_ioctl_bridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bootdata_ioctl_bridge.sv
// Unpacks 32-bit host boot-data words (req-edge / ack-pulse) into ioctl_* writes of OUT_BYTES bytes.
// Word accept to first strobe is 2 cycles; ioctl_wait stalls the pending strobe and the host simply waits for ack.
module bootdata_ioctl_bridge #(
  parameter int OUT_BYTES = 1,
  parameter int ADDR_W    = 27,
  parameter int SIZE_W    = 16,
  parameter int WR_GAP    = 2
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [31:0]            host_bootdata,
  input  logic                   host_bootdata_req,
  output logic                   host_bootdata_ack,
  input  logic                   host_bootdata_download,
  input  logic [SIZE_W-1:0]      host_bootdata_size,
  input  logic [2:0]             host_file_type,
  input  logic                   ioctl_wait,
  output logic                   ioctl_download,
  output logic [15:0]            ioctl_index,
  output logic                   ioctl_wr,
  output logic [ADDR_W-1:0]      ioctl_addr,
  output logic [8*OUT_BYTES-1:0] ioctl_dout,
  output logic                   load_done,
  output logic                   addr_overflow
);

  localparam int         CNT_W = SIZE_W + 1;
  localparam logic [2:0] STEP  = 3'(OUT_BYTES);
  localparam logic [3:0] GAP_N = 4'(WR_GAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REQ,
    S_EMIT,
    S_GAP,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_req_q;
  logic                r_dl_q;
  logic [31:0]         r_word;
  logic [2:0]          r_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [SIZE_W-1:0]   r_size;
  logic [3:0]          r_gap_cnt;
  logic                r_gap_to_req;

  logic                w_req_rise;
  logic                w_dl_rise;
  logic                w_dl_fall;
  logic                w_start;
  logic                w_accept;
  logic                w_latch;
  logic                w_emit;
  logic                w_finish;
  logic                w_gap_load;
  logic                w_gap_to_req_next;
  logic [2:0]          w_ptr_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_size_hit;
  logic                w_word_done;
  logic [ADDR_W:0]     w_addr_inc;
  logic [8*OUT_BYTES-1:0] w_dout;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

  assign w_req_rise  = host_bootdata_req & ~r_req_q;
  assign w_dl_rise   = host_bootdata_download & ~r_dl_q;
  assign w_dl_fall   = ~host_bootdata_download & r_dl_q;
  assign w_ptr_next  = r_ptr + STEP;
  assign w_cnt_next  = r_cnt + CNT_W'(OUT_BYTES);
  assign w_word_done = w_ptr_next[2];
  assign w_size_hit  = (r_size != '0) && (w_cnt_next >= {1'b0, r_size});
  assign w_addr_inc  = {1'b0, ioctl_addr} + (ADDR_W+1)'(OUT_BYTES);

  // Lanes past the end of a sized file are zero-filled.
  always_comb begin
    w_dout = '0;
    for (int l = 0; l < OUT_BYTES; l++) begin
      if ((r_size == '0) || ((r_cnt + CNT_W'(l)) < {1'b0, r_size}))
        w_dout[8*l +: 8] = word_byte(r_word, r_ptr[1:0] + 2'(l));
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_start           = 1'b0;
    w_accept          = 1'b0;
    w_latch           = 1'b0;
    w_emit            = 1'b0;
    w_finish          = 1'b0;
    w_gap_load        = 1'b0;
    w_gap_to_req_next = r_gap_to_req;
    if (w_dl_fall && (r_state != S_IDLE) && (r_state != S_FINISH)) begin
      w_finish     = 1'b1;
      w_state_next = S_FINISH;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dl_rise) begin
            w_start      = 1'b1;
            w_state_next = S_WAIT_REQ;
          end
        end
        S_WAIT_REQ: begin
          if (w_req_rise) begin
            w_accept     = 1'b1;
            w_latch      = 1'b1;
            w_state_next = S_EMIT;
          end
        end
        S_EMIT: begin
          if (!ioctl_wait) begin
            w_emit = 1'b1;
            if (w_size_hit) begin
              w_state_next = S_DRAIN;
            end else if (WR_GAP == 0) begin
              w_state_next = w_word_done ? S_WAIT_REQ : S_EMIT;
            end else begin
              w_state_next      = S_GAP;
              w_gap_load        = 1'b1;
              w_gap_to_req_next = w_word_done;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt <= 4'd1)
            w_state_next = r_gap_to_req ? S_WAIT_REQ : S_EMIT;
        end
        S_DRAIN: begin
          w_accept = w_req_rise;
        end
        S_FINISH: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_req_q           <= 1'b0;
      r_dl_q            <= 1'b0;
      r_word            <= '0;
      r_ptr             <= '0;
      r_cnt             <= '0;
      r_size            <= '0;
      r_gap_cnt         <= '0;
      r_gap_to_req      <= 1'b0;
      host_bootdata_ack <= 1'b0;
      ioctl_download    <= 1'b0;
      ioctl_index       <= '0;
      ioctl_wr          <= 1'b0;
      ioctl_addr        <= '0;
      ioctl_dout        <= '0;
      load_done         <= 1'b0;
      addr_overflow     <= 1'b0;
    end else begin
      r_state           <= w_state_next;
      r_req_q           <= host_bootdata_req;
      r_dl_q            <= host_bootdata_download;
      host_bootdata_ack <= w_accept;
      ioctl_wr          <= w_emit;
      load_done         <= w_finish;
      r_gap_to_req      <= w_gap_to_req_next;

      if (w_start) begin
        ioctl_download <= 1'b1;
        ioctl_index    <= {13'b0, host_file_type};
        r_size         <= host_bootdata_size;
        r_cnt          <= '0;
        ioctl_addr     <= '0;
        addr_overflow  <= 1'b0;
      end else if (ioctl_wr) begin
        // Address moves on the cycle after its strobe; a carry out means it wrapped.
        ioctl_addr <= w_addr_inc[ADDR_W-1:0];
        if (w_addr_inc[ADDR_W])
          addr_overflow <= 1'b1;
      end

      if (w_finish)
        ioctl_download <= 1'b0;

      if (w_latch) begin
        r_word <= host_bootdata;
        r_ptr  <= '0;
      end

      if (w_emit) begin
        ioctl_dout <= w_dout;
        r_ptr      <= w_ptr_next;
        r_cnt      <= w_cnt_next;
      end

      if (w_gap_load)
        r_gap_cnt <= GAP_N;
      else if (r_state == S_GAP)
        r_gap_cnt <= r_gap_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_bootdata_ioctl_bridge.sv
// Bench: three bridge configurations share the host-side stimulus; the selected one is checked against a byte-stream model.
`timescale 1ns/1ps
module tb_bootdata_ioctl_bridge;

  logic        clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset;
  logic [31:0] host_bootdata;
  logic        host_bootdata_req;
  logic        host_bootdata_download;
  logic [15:0] host_bootdata_size;
  logic [2:0]  host_file_type;
  logic        ioctl_wait;

  logic        ack0, ack1, ack2, dl0, dl1, dl2, wr0, wr1, wr2, ld0, ld1, ld2, ov0, ov1, ov2;
  logic [15:0] idx0, idx1, idx2;
  logic [26:0] addr0, addr1;
  logic [3:0]  addr2;
  logic [7:0]  dout0, dout2;
  logic [15:0] dout1;

  bootdata_ioctl_bridge #(.OUT_BYTES(1), .ADDR_W(27), .SIZE_W(16), .WR_GAP(2)) u_dut0 (
    .clk_sys(clk_sys), .reset(reset), .host_bootdata(host_bootdata),
    .host_bootdata_req(host_bootdata_req), .host_bootdata_ack(ack0),
    .host_bootdata_download(host_bootdata_download), .host_bootdata_size(host_bootdata_size),
    .host_file_type(host_file_type), .ioctl_wait(ioctl_wait), .ioctl_download(dl0),
    .ioctl_index(idx0), .ioctl_wr(wr0), .ioctl_addr(addr0), .ioctl_dout(dout0),
    .load_done(ld0), .addr_overflow(ov0));

  bootdata_ioctl_bridge #(.OUT_BYTES(2), .ADDR_W(27), .SIZE_W(16), .WR_GAP(1)) u_dut1 (
    .clk_sys(clk_sys), .reset(reset), .host_bootdata(host_bootdata),
    .host_bootdata_req(host_bootdata_req), .host_bootdata_ack(ack1),
    .host_bootdata_download(host_bootdata_download), .host_bootdata_size(host_bootdata_size),
    .host_file_type(host_file_type), .ioctl_wait(ioctl_wait), .ioctl_download(dl1),
    .ioctl_index(idx1), .ioctl_wr(wr1), .ioctl_addr(addr1), .ioctl_dout(dout1),
    .load_done(ld1), .addr_overflow(ov1));

  bootdata_ioctl_bridge #(.OUT_BYTES(1), .ADDR_W(4), .SIZE_W(16), .WR_GAP(0)) u_dut2 (
    .clk_sys(clk_sys), .reset(reset), .host_bootdata(host_bootdata),
    .host_bootdata_req(host_bootdata_req), .host_bootdata_ack(ack2),
    .host_bootdata_download(host_bootdata_download), .host_bootdata_size(host_bootdata_size),
    .host_file_type(host_file_type), .ioctl_wait(ioctl_wait), .ioctl_download(dl2),
    .ioctl_index(idx2), .ioctl_wr(wr2), .ioctl_addr(addr2), .ioctl_dout(dout2),
    .load_done(ld2), .addr_overflow(ov2));

  int          cur = 0;
  logic        o_ack, o_dl, o_wr, o_ld, o_ov;
  logic [15:0] o_idx;
  logic [26:0] o_addr;
  logic [15:0] o_dout;

  always_comb begin
    o_ack = ack0; o_dl = dl0; o_wr = wr0; o_ld = ld0; o_ov = ov0;
    o_idx = idx0; o_addr = addr0; o_dout = 16'(dout0);
    if (cur == 1) begin
      o_ack = ack1; o_dl = dl1; o_wr = wr1; o_ld = ld1; o_ov = ov1;
      o_idx = idx1; o_addr = addr1; o_dout = dout1;
    end else if (cur == 2) begin
      o_ack = ack2; o_dl = dl2; o_wr = wr2; o_ld = ld2; o_ov = ov2;
      o_idx = idx2; o_addr = 27'(addr2); o_dout = 16'(dout2);
    end
  end

  function automatic int cfg_ob(input int k);
    return (k == 1) ? 2 : 1;
  endfunction
  function automatic int cfg_aw(input int k);
    return (k == 2) ? 4 : 27;
  endfunction
  function automatic int cfg_gap(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 0);
  endfunction

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (inst %0d)", tag, got, exp, cur);
    end
  endtask

  int          cyc = 0;
  int          acks = 0;
  int          last_ack_cyc = 0;
  int          cur_size = 0;
  bit          rand_wait = 1'b0;
  logic [26:0] obs_addr[$];
  logic [15:0] obs_dout[$];
  int          obs_cyc[$];
  logic [31:0] words_q[$];

  // One clock: inputs set before the edge, outputs sampled 1ns after it.
  task automatic tick();
    logic w_applied;
    w_applied = ioctl_wait;
    @(posedge clk_sys);
    #1;
    cyc++;
    if (o_wr) begin
      obs_addr.push_back(o_addr);
      obs_dout.push_back(o_dout);
      obs_cyc.push_back(cyc);
      check_val("wr_under_wait", 32'(w_applied), 0);
    end
    if (o_ack) acks++;
    if (rand_wait) ioctl_wait = ($urandom_range(0, 3) == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    host_bootdata_req = 1'b0;
    host_bootdata_download = 1'b0;
    ioctl_wait = 1'b0;
    rand_wait = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_dl(input int k, input logic [2:0] ftype, input int size);
    cur = k;
    cur_size = size;
    obs_addr.delete(); obs_dout.delete(); obs_cyc.delete(); words_q.delete();
    acks = 0;
    host_file_type = ftype;
    host_bootdata_size = 16'(size);
    host_bootdata_download = 1'b1;
    tick();
    check_val("dl_start", 32'(o_dl), 1);
    check_val("index", 32'(o_idx), 32'(ftype));
    check_val("addr_clr", 32'(o_addr), 0);
    check_val("ovf_clr", 32'(o_ov), 0);
  endtask

  function automatic int exp_strobes(input int nw);
    int len;
    len = 4 * nw;
    if (cur_size != 0 && cur_size < len) len = cur_size;
    return (len + cfg_ob(cur) - 1) / cfg_ob(cur);
  endfunction

  task automatic wait_strobes(input int n);
    int budget;
    budget = 400;
    while (obs_dout.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    if (obs_dout.size() < n) check_val("strobe_timeout", obs_dout.size(), n);
  endtask

  task automatic send_word(input logic [31:0] w);
    int a0;
    a0 = acks;
    host_bootdata = w;
    host_bootdata_req = 1'b1;
    words_q.push_back(w);
    tick();
    last_ack_cyc = cyc;
    check_val("ack_edge", 32'(o_ack), 1);
    wait_strobes(exp_strobes(words_q.size()));
    repeat (cfg_gap(cur) + 2) tick();
    host_bootdata_req = 1'b0;
    tick();
    check_val("ack_once", acks - a0, 1);
  endtask

  // Expected writes come from the accepted words viewed as one byte stream truncated to the size.
  task automatic compare_model();
    logic [7:0]  bytes[$];
    logic [31:0] wd;
    logic [15:0] d;
    int len, ob, aw, n, g, span;
    ob = cfg_ob(cur);
    aw = cfg_aw(cur);
    foreach (words_q[i]) begin
      wd = words_q[i];
      for (int b = 0; b < 4; b++) bytes.push_back(wd[31-8*b -: 8]);
    end
    while (cur_size != 0 && bytes.size() > cur_size) void'(bytes.pop_back());
    len = bytes.size();
    n = (len + ob - 1) / ob;
    check_val("n_strobes", obs_dout.size(), n);
    for (int s = 0; s < n && s < obs_dout.size(); s++) begin
      g = s * ob;
      d = {8'h00, bytes[g]};
      if (ob == 2 && g + 1 < len) d[15:8] = bytes[g+1];
      check_val("dout", 32'(obs_dout[s]), 32'(d));
      check_val("addr", 32'(obs_addr[s]), g % (1 << aw));
    end
    span = n * ob;
    check_val("addr_final", 32'(o_addr), span % (1 << aw));
    check_val("ovf", 32'(o_ov), 32'(span >= (1 << aw)));
  endtask

  task automatic finish_dl();
    host_bootdata_download = 1'b0;
    tick();
    check_val("dl_low", 32'(o_dl), 0);
    check_val("load_done", 32'(o_ld), 1);
    check_val("no_ack_on_fall", 32'(o_ack), 0);
    tick();
    check_val("load_done_1cyc", 32'(o_ld), 0);
    compare_model();
  endtask

  initial begin
    host_bootdata = '0;
    host_bootdata_size = '0;
    host_file_type = '0;
    do_reset();

    check_val("rst_dl", 32'(o_dl), 0);
    check_val("rst_wr", 32'(o_wr), 0);
    check_val("rst_ack", 32'(o_ack), 0);
    check_val("rst_addr", 32'(o_addr), 0);
    check_val("rst_dout", 32'(o_dout), 0);
    check_val("rst_index", 32'(o_idx), 0);
    check_val("rst_ld", 32'(o_ld), 0);
    check_val("rst_ovf", 32'(o_ov), 0);

    // Byte mode, size 6: second word partially written, third word acked in DRAIN.
    start_dl(0, 3'b001, 6);
    send_word(32'h11223344);
    check_val("first_wr_lat", obs_cyc[0] - last_ack_cyc, 1);
    for (int i = 1; i < 4; i++) check_val("wr_spacing", obs_cyc[i] - obs_cyc[i-1], 3);
    send_word(32'h55667788);
    check_val("wr_spacing2", obs_cyc[5] - obs_cyc[4], 3);
    send_word(32'hDEADBEEF);
    check_val("drain_dl", 32'(o_dl), 1);
    finish_dl();

    // Wide mode, odd size 5.
    start_dl(1, 3'b010, 5);
    send_word(32'hAABBCCDD);
    send_word(32'hEE000000);
    send_word(32'h12345678);
    finish_dl();

    // Unlimited size, wait held after first strobe, fall coincident with a req edge.
    start_dl(0, 3'b000, 0);
    host_bootdata = 32'h11223344;
    host_bootdata_req = 1'b1;
    words_q.push_back(32'h11223344);
    tick();
    check_val("hold_ack", 32'(o_ack), 1);
    tick();
    check_val("first_wr_t2", 32'(o_wr), 1);
    ioctl_wait = 1'b1;
    repeat (10) tick();
    check_val("hold_no_wr", obs_dout.size(), 1);
    ioctl_wait = 1'b0;
    tick();
    check_val("wr_after_hold", 32'(o_wr), 1);
    check_val("hold_addr", 32'(o_addr), 1);
    check_val("hold_dout", 32'(o_dout), 32'h22);
    wait_strobes(4);
    repeat (4) tick();
    host_bootdata_req = 1'b0;
    tick();
    send_word($urandom);
    send_word($urandom);
    host_bootdata_req = 1'b1;
    finish_dl();
    host_bootdata_req = 1'b0;

    // 4-bit address: wrap sets overflow, held after finish, cleared on restart.
    start_dl(2, 3'b000, 0);
    for (int i = 0; i < 5; i++) send_word($urandom);
    finish_dl();
    tick();
    check_val("ovf_held", 32'(o_ov), 1);
    start_dl(2, 3'b000, 0);
    finish_dl();

    // Randomised downloads with random back-pressure.
    for (int it = 0; it < 12; it++) begin
      int k, sz, nw;
      k  = $urandom_range(0, 2);
      sz = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 24);
      nw = $urandom_range(1, 7);
      start_dl(k, 3'($urandom_range(0, 7)), sz);
      rand_wait = 1'b1;
      for (int w = 0; w < nw; w++) send_word($urandom);
      finish_dl();
      rand_wait = 1'b0;
      ioctl_wait = 1'b0;
    end

    // Reset while EMIT is about to strobe, with file type 010 latched.
    start_dl(0, 3'b010, 0);
    host_bootdata = 32'hCAFEF00D;
    host_bootdata_req = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_val("mid_rst_dl", 32'(o_dl), 0);
    check_val("mid_rst_wr", 32'(o_wr), 0);
    check_val("mid_rst_ack", 32'(o_ack), 0);
    check_val("mid_rst_index", 32'(o_idx), 0);
    check_val("mid_rst_addr", 32'(o_addr), 0);
    check_val("mid_rst_dout", 32'(o_dout), 0);
    check_val("mid_rst_ovf", 32'(o_ov), 0);
    reset = 1'b0;
    host_bootdata_req = 1'b0;
    host_bootdata_download = 1'b0;
    tick();
    check_val("mid_rst_no_ld", 32'(o_ld), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
